// File: rtl/i2s_rx_pkg.sv
// Shared audio definitions for the I2S receive path: channel and state encodings,
// default word geometry shared with the transmit side.
package i2s_rx_pkg;

  localparam int unsigned DefaultSampleWidth = 16;
  localparam int unsigned DefaultMaxBits     = 32;

  localparam logic ChanLeft  = 1'b0;
  localparam logic ChanRight = 1'b1;

  typedef enum logic [1:0] {
    StWaitSync,
    StShift,
    StHold
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// Codec-facing serial lines plus the parallel stereo sample outputs of the receiver.
interface i2s_rx_if
  import i2s_rx_pkg::*;
#(
  parameter int unsigned SampleWidth = DefaultSampleWidth
) ();

  logic                   bit_clk;
  logic                   frame_clk;
  logic                   sdata;
  logic [SampleWidth-1:0] left_sample;
  logic [SampleWidth-1:0] right_sample;
  logic                   sample_valid;
  logic                   frame_err;

  // Codec / consumer side
  modport master (
    output bit_clk, frame_clk, sdata,
    input  left_sample, right_sample, sample_valid, frame_err
  );

  // Receiver side
  modport slave (
    input  bit_clk, frame_clk, sdata,
    output left_sample, right_sample, sample_valid, frame_err
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer for a bundle of asynchronous inputs plus registered rising-edge
// detect; q_o is delayed one extra flop so it lines up with rise_o.
module i2s_sync_edge #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] meta_q, sync_q, dly_q, rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
      rise_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= sync_q & ~dly_q;
    end
  end

  assign q_o    = dly_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S capture: oversamples BCLK/LRCLK/SDATA in the system clock domain and emits
// left/right PCM pairs with a one-cycle valid strobe, flagging short/overlong words.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned SampleWidth    = DefaultSampleWidth,
  parameter int unsigned MaxBitsPerChan = DefaultMaxBits
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  i2s_rx_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(MaxBitsPerChan + 2);

  // Async assert, sync deassert
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  logic [2:0] sync_q3, rise3;
  logic       bclk_rise, lr, sd;
  logic       unused_sync;

  i2s_sync_edge #(
    .Width (3)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_n_int),
    .d_i    ({bus_io.sdata, bus_io.frame_clk, bus_io.bit_clk}),
    .q_o    (sync_q3),
    .rise_o (rise3)
  );

  assign bclk_rise   = rise3[0];
  assign lr          = sync_q3[1];
  assign sd          = sync_q3[2];
  assign unused_sync = ^{rise3[2:1], sync_q3[0]};

  rx_state_e              state_q, state_d;
  logic                   chan_q, chan_d;
  logic                   lr_prev_q, lr_prev_d;
  logic                   left_ok_q, left_ok_d;
  logic [CntW-1:0]        bitcnt_q, bitcnt_d, cnt_inc;
  logic [SampleWidth-1:0] shift_q, shift_d, shifted;
  logic [SampleWidth-1:0] left_hold_q, left_hold_d;
  logic [SampleWidth-1:0] left_q, left_d, right_q, right_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic                   lr_chg, word_done, overlong;

  assign lr_chg    = (lr != lr_prev_q);
  assign cnt_inc   = bitcnt_q + CntW'(1);
  assign word_done = (cnt_inc == CntW'(SampleWidth));
  assign overlong  = (cnt_inc > CntW'(MaxBitsPerChan));
  assign shifted   = {shift_q[SampleWidth-2:0], sd};

  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) state_q <= StWaitSync;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bclk_rise) begin
      unique case (state_q)
        StWaitSync: if (lr_chg) state_d = StShift;
        StShift:    if (!lr_chg && word_done) state_d = StHold;
        StHold: begin
          if (lr_chg)        state_d = StShift;
          else if (overlong) state_d = StWaitSync;
        end
        default: state_d = StWaitSync;
      endcase
    end
  end

  always_comb begin
    chan_d      = chan_q;
    lr_prev_d   = lr_prev_q;
    left_ok_d   = left_ok_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    if (bclk_rise) begin
      lr_prev_d = lr;
      // The edge that reveals an LR change carries the previous word's LSB slot; skip it.
      if (lr_chg) begin
        chan_d   = lr;
        bitcnt_d = '0;
        if (state_q == StShift) begin
          err_d     = 1'b1;
          left_ok_d = 1'b0;
        end
      end else if (state_q == StShift) begin
        shift_d  = shifted;
        bitcnt_d = cnt_inc;
        if (word_done) begin
          if (chan_q == ChanLeft) begin
            left_hold_d = shifted;
            left_ok_d   = 1'b1;
          end else if (left_ok_q) begin
            left_d    = left_hold_q;
            right_d   = shifted;
            valid_d   = 1'b1;
            left_ok_d = 1'b0;
          end
        end
      end else if (state_q == StHold) begin
        bitcnt_d = cnt_inc;
        if (overlong) begin
          err_d     = 1'b1;
          left_ok_d = 1'b0;
          bitcnt_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      chan_q      <= ChanLeft;
      lr_prev_q   <= 1'b0;
      left_ok_q   <= 1'b0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      chan_q      <= chan_d;
      lr_prev_q   <= lr_prev_d;
      left_ok_q   <= left_ok_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.left_sample  = left_q;
  assign bus_io.right_sample = right_q;
  assign bus_io.sample_valid = valid_q;
  assign bus_io.frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: a codec model streams I2S frames and queues the pairs
// that must appear; an independent monitor pops and compares on every sample_valid.
module tb_i2s_rx;

  localparam int SW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  i2s_rx_if #(.SampleWidth(SW)) bus ();

  i2s_rx #(
    .SampleWidth    (SW),
    .MaxBitsPerChan (32)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;
  int err_exp     = 0;
  int err_slot    = -1;
  int slot_idx    = 0;
  int hp          = 80;
  logic [2*SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sample_valid) begin
        logic [2*SW-1:0] e;
        if (bus.frame_err) check("valid_err_same_cycle", {31'd0, bus.frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got L=%0h R=%0h, expected no pulse",
                   bus.left_sample, bus.right_sample);
        end else begin
          e = exp_q.pop_front();
          check("left_sample", {16'd0, bus.left_sample}, {16'd0, e[2*SW-1:SW]});
          check("right_sample", {16'd0, bus.right_sample}, {16'd0, e[SW-1:0]});
        end
      end
      if (bus.frame_err) begin
        err_seen++;
        err_slot = slot_idx;
      end
    end
  end

  // One half-frame: slot 0 carries the previous (zero) LSB, slots 1..16 the word MSB first.
  task automatic send_half(input logic lr, input logic [SW-1:0] word, input int nslots);
    for (int s = 0; s < nslots; s++) begin
      slot_idx      = s;
      bus.bit_clk   = 1'b0;
      bus.frame_clk = lr;
      bus.sdata     = (s >= 1 && s <= SW) ? word[SW-s] : 1'b0;
      #(hp);
      bus.bit_clk   = 1'b1;
      #(hp);
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input bit expect_valid);
    if (expect_valid) exp_q.push_back({l, r});
    send_half(1'b0, l, 32);
    send_half(1'b1, r, 32);
  endtask

  task automatic settle(input string tag);
    repeat (20) @(posedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_err_count"}, err_seen, err_exp);
  endtask

  initial begin
    bus.bit_clk   = 1'b0;
    bus.frame_clk = 1'b0;
    bus.sdata     = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_left", {16'd0, bus.left_sample}, 32'd0);
    check("rst_right", {16'd0, bus.right_sample}, 32'd0);
    check("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
    check("rst_err", {31'd0, bus.frame_err}, 32'd0);

    // Standard frames: first one only synchronises
    send_frame(16'h1234, 16'hABCD, 1'b0);
    repeat (3) send_frame(16'h1234, 16'hABCD, 1'b1);
    settle("std");

    // Sign/MSB alignment
    repeat (3) send_frame(16'h8000, 16'h7FFF, 1'b1);
    settle("sign");

    // Short left word (10 bits) abandons the pair
    send_half(1'b0, 16'h5555, 11);
    err_exp++;
    send_half(1'b1, 16'h2222, 32);
    send_frame(16'h0F0F, 16'hF0F0, 1'b1);
    settle("short");

    // Overlong left half: 40 bit clocks low
    send_half(1'b0, 16'h1111, 40);
    err_exp++;
    check("overlong_err_slot", err_slot, 33);
    send_half(1'b1, 16'h2222, 32);
    send_frame(16'hCAFE, 16'hBEEF, 1'b1);
    settle("overlong");

    // Reset in the middle of the right word
    send_half(1'b0, 16'h3333, 32);
    send_half(1'b1, 16'h4444, 8);
    rst_n = 1'b0;
    #1;
    check("midrst_left", {16'd0, bus.left_sample}, 32'd0);
    check("midrst_right", {16'd0, bus.right_sample}, 32'd0);
    check("midrst_valid", {31'd0, bus.sample_valid}, 32'd0);
    bus.frame_clk = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(16'h5A5A, 16'hA5A5, 1'b0);
    send_frame(16'h1357, 16'h2468, 1'b1);
    settle("reset");

    // Minimum oversampling (clk/BCLK = 4), random phase and data
    hp = 20;
    @(posedge clk);
    #($urandom_range(1, 9));
    for (int f = 0; f < 100; f++) begin
      send_frame(SW'($urandom), SW'($urandom), 1'b1);
    end
    settle("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Capture side of the codec serial audio link: deserialises ADC data from the codec's I2S output (bit clock, frame/LR clock, serial data) into parallel left/right PCM samples.
- Runs entirely in the system clock domain. The external `bit_clk` and `frame_clk` are treated as asynchronous data, oversampled and edge-detected.
- Feeds stereo sample pairs with a one-cycle valid strobe to downstream DSP/record logic. It is the receive counterpart of the APU's I2S transmit path.

Parameters:
- SAMPLE_WIDTH, 16, bits captured per channel, MSB first; legal range 8..32.
- MAX_BITS_PER_CHAN, 32, bit-clock edges per half-frame beyond which the word is flagged as an error; must be ≥ SAMPLE_WIDTH.

Ports:
- clk  input  1  system clock; 50 MHz nominal, must be ≥ 4× bit_clk frequency.
- reset  input  1  asynchronous, active-low reset.
- bit_clk  input  1  codec serial bit clock (BCLK), asynchronous to clk.
- frame_clk  input  1  codec LR clock; 0 = left, 1 = right.
- sdata  input  1  codec serial ADC data.
- left_sample  output  SAMPLE_WIDTH  last complete left word, two's complement.
- right_sample  output  SAMPLE_WIDTH  last complete right word.
- sample_valid  output  1  one-cycle pulse when a new left/right pair is presented.
- frame_err  output  1  one-cycle pulse on a short or overlong channel word.

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0, state WAIT_SYNC, shift register 0, bit counter 0, left_ok 0.
- Input conditioning:
  - bit_clk, frame_clk and sdata each pass through an identical 2-flop synchronizer, so they stay mutually aligned.
  - bclk_rise is high for one clk when the synchronized bit_clk goes 0→1.
  - All protocol actions below happen only on cycles where bclk_rise = 1, using synchronized frame_clk and sdata values.
- LR change detect: lr_chg = (sync frame_clk ≠ lr_prev); lr_prev updates on every bclk_rise.
- I2S one-bit delay: the rising edge on which lr_chg is seen carries the previous word's LSB slot. That bit is ignored. The MSB is taken on the next rising edge.
- States:
  - WAIT_SYNC: ignore data. On lr_chg → SHIFT, chan = new frame_clk, bitcnt = 0. This discards the partial frame present after reset.
  - SHIFT: on each rising edge, shift sdata into the LSB of the shift register and increment bitcnt.
    - When bitcnt reaches SAMPLE_WIDTH: latch the word into a channel holding register (left if chan = 0, else right), then → HOLD.
    - On lr_chg before SAMPLE_WIDTH bits: pulse frame_err, drop the word, clear left_ok, restart SHIFT for the new channel.
  - HOLD: count edges, ignore data.
    - On lr_chg: restart SHIFT for the new channel.
    - If the count exceeds MAX_BITS_PER_CHAN with no lr_chg: pulse frame_err, clear left_ok, → WAIT_SYNC.
- Pairing:
  - A completed left word sets left_ok.
  - A completed right word with left_ok = 1 updates left_sample and right_sample together and pulses sample_valid in the clk cycle after the bclk_rise that shifted in the right word's last bit. left_ok then clears.
  - A right word without left_ok is dropped silently: no valid, no error.
- Latency: last right-channel bit on the sdata pin → sample_valid is at most 4 clk cycles after the corresponding bit_clk pin rise (2 sync, 1 edge detect, 1 register).
- Outputs hold their values between valid pulses. sample_valid and frame_err never assert in the same cycle; an error abandons the pair.
- Reset mid-word: all state is lost and the block resynchronises via WAIT_SYNC. The first valid pair after reset therefore needs at least one full frame.
- bit_clk stopped: the FSM freezes in place with no timeout in the clk domain. It resumes correctly when edges return.

Decomposition:
- Shared audio package holds:
  - channel encodings CHAN_LEFT = 0, CHAN_RIGHT = 1;
  - state encoding WAIT_SYNC, SHIFT, HOLD;
  - default SAMPLE_WIDTH, shared with the transmit path.
- One sub-module, i2s_sync_edge: 2-flop synchronizer for the three inputs plus the bclk_rise detector. The same module is reusable for the codec I2C lines.

Test Plan:
- Standard frame: BCLK 3.072 MHz, 32 bits/chan, left = 16'h1234, right = 16'hABCD, trailing bits 0 → after one sync frame, sample_valid pulses once per frame, left_sample = 16'h1234, right_sample = 16'hABCD.
- Sign/MSB check: left = 16'h8000, right = 16'h7FFF over 3 frames → exactly 3 valid pulses with exact values. Confirms one-bit delay alignment (no shift by one).
- Short word: frame_clk toggles after 10 left bits → one frame_err pulse, no sample_valid for that frame; the next complete frame yields valid with correct data.
- Overlong: frame_clk held low for 40 bit clocks → frame_err pulse at edge 33 and return to WAIT_SYNC; a valid pair resumes after the next full frame.
- Async reset asserted mid-right-word (bit 7) → outputs read 0 immediately; no valid until a complete left+right pair after the next LR edge.
- Minimum oversampling: clk/BCLK = 4 with random phase offset, 100 frames of random data → all 100 pairs match the transmitted data with no frame_err.
